// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and data memory (slave).
// Handshake: the master raises bus_req with bus_we/addr/be/wdata and holds all of them stable
// until a cycle where the slave drives bus_ack or bus_err; that cycle ends the transfer.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory stage: turns decoded loads/stores into one req/ack bus transfer, stalls the core
// until it ends, returns extended load data and reports alignment, width and bus faults.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memSignWidth,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic [31:0] fault_cause,
    output logic [31:0] fault_addr,
    output logic [1:0]  dbg_state,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [31:0] timer;
    logic        is_store_q;
    logic [2:0]  width_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic [31:0] cause_q;

    logic        access;
    logic        width_bad;
    logic        misaligned;
    logic        bad;
    logic [31:0] bad_cause;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic        timeout_hit;

    // Request decode for the instruction currently presented by decode.
    always_comb begin
        access = memRead | memWrite;
        if (memWrite)
            width_bad = memSignWidth[2] | (memSignWidth[1:0] == 2'b11);
        else
            width_bad = (memSignWidth[1:0] == 2'b11) | (memSignWidth == 3'd6);
        misaligned = ((memSignWidth[1:0] == 2'd1) & addr[0])
                   | ((memSignWidth[1:0] == 2'd2) & (addr[1:0] != 2'b00));
        bad       = access & (width_bad | misaligned);
        bad_cause = width_bad ? 32'd2 : (memWrite ? 32'd6 : 32'd4);
        case (memSignWidth[1:0])
            2'd0: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            2'd1: begin
                be_n    = 4'b0011 << {addr[1], 1'b0};
                wdata_n = {2{wdata[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = wdata;
            end
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Lane selection uses the latched request, not the live decode inputs.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = bus.bus_rdata[7:0];
            2'd1:    ld_byte = bus.bus_rdata[15:8];
            2'd2:    ld_byte = bus.bus_rdata[23:16];
            default: ld_byte = bus.bus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (width_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'd0, ld_byte};
            3'd5:    ld_ext = {16'd0, ld_half};
            default: ld_ext = bus.bus_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            is_store_q    <= 1'b0;
            width_q       <= '0;
            addr_q        <= '0;
            rdata_q       <= '0;
            fault_q       <= 1'b0;
            cause_q       <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !bad) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= memWrite;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= be_n;
                        bus.bus_wdata <= memWrite ? wdata_n : 32'd0;
                        is_store_q    <= memWrite;
                        width_q       <= memSignWidth;
                        addr_q        <= addr;
                        fault_q       <= 1'b0;
                        rdata_q       <= '0;
                        timer         <= '0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    timer <= timer + 32'd1;
                    // bus_err outranks a same-cycle ack; an ack on the last timer cycle still counts.
                    if (bus.bus_err || (timeout_hit && !bus.bus_ack)) begin
                        fault_q <= 1'b1;
                        cause_q <= is_store_q ? 32'd7 : 32'd5;
                    end else if (bus.bus_ack) begin
                        rdata_q <= is_store_q ? 32'd0 : ld_ext;
                    end
                    if (bus.bus_err || bus.bus_ack || timeout_hit) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_addr  <= '0;
                        bus.bus_be    <= '0;
                        bus.bus_wdata <= '0;
                        timer         <= '0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    fault_q <= 1'b0;
                    rdata_q <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Illegal requests trap in the same cycle; bus faults surface one cycle later in DONE.
    always_comb begin
        stall       = ((state == IDLE) && access && !bad) || (state == BUSY);
        fault       = 1'b0;
        fault_cause = '0;
        fault_addr  = '0;
        if (state == IDLE && bad) begin
            fault       = 1'b1;
            fault_cause = bad_cause;
            fault_addr  = addr;
        end else if (state == DONE && fault_q) begin
            fault       = 1'b1;
            fault_cause = cause_q;
            fault_addr  = addr_q;
        end
        rdata     = (state == DONE) ? rdata_q : 32'd0;
        dbg_state = state;
    end
endmodule
